// File: rtl/eaglesong_pkg.sv
// +--------------------------------------------------------------------+
// | eaglesong_pkg : shared types and sizes for the eaglesong blocks    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package eaglesong_pkg;

  localparam int HEADER_BYTES = 24;
  localparam int NONCE_BYTES  = 8;
  localparam int MSG_BYTES    = 32;
  localparam int DIGEST_W     = 256;
  localparam int HEADER_W     = HEADER_BYTES * 8;
  localparam int NONCE_W      = NONCE_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/eaglesong_nonce_search_if.sv
// +--------------------------------------------------------------------+
// | eaglesong_nonce_search_if : job, result and digest-core signals    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

interface eaglesong_nonce_search_if;
  import eaglesong_pkg::*;

  logic                job_valid;
  logic                job_ready;
  logic [HEADER_W-1:0] job_header;
  logic [NONCE_W-1:0]  job_nonce_start;
  logic [31:0]         job_nonce_count;
  logic [DIGEST_W-1:0] job_target;
  logic                abort;
  logic                busy;

  logic                res_valid;
  logic                res_found;
  logic                res_timeout;
  logic [NONCE_W-1:0]  res_nonce;
  logic [DIGEST_W-1:0] res_digest;

  logic [DIGEST_W-1:0] dg_input_val;
  logic [6:0]          dg_input_length_bytes;
  logic                dg_start_eval;
  logic [DIGEST_W-1:0] dg_output_val;
  logic                dg_eval_output_ready;

  modport slave (
    input  job_valid, job_header, job_nonce_start, job_nonce_count, job_target, abort,
    input  dg_output_val, dg_eval_output_ready,
    output job_ready, busy, res_valid, res_found, res_timeout, res_nonce, res_digest,
    output dg_input_val, dg_input_length_bytes, dg_start_eval
  );

  modport master (
    output job_valid, job_header, job_nonce_start, job_nonce_count, job_target, abort,
    output dg_output_val, dg_eval_output_ready,
    input  job_ready, busy, res_valid, res_found, res_timeout, res_nonce, res_digest,
    input  dg_input_val, dg_input_length_bytes, dg_start_eval
  );

endinterface

`default_nettype wire

// File: rtl/eaglesong_nonce_search.sv
// +--------------------------------------------------------------------+
// | eaglesong_nonce_search : walks a nonce range through an external   |
// | digest core until a digest falls below the target. Revision 1.0    |
// +--------------------------------------------------------------------+
`default_nettype none

module eaglesong_nonce_search
  import eaglesong_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  eaglesong_nonce_search_if.slave  bus
);

  localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state;
  state_t              state_nxt;
  logic [HEADER_W-1:0] header;
  logic [NONCE_W-1:0]  nonce;
  logic [31:0]         remaining;
  logic [DIGEST_W-1:0] target;
  logic [CNT_W-1:0]    wait_cnt;
  logic                res_found;
  logic                res_timeout;
  logic [NONCE_W-1:0]  res_nonce;
  logic [DIGEST_W-1:0] res_digest;
  logic                accept;
  logic                found;
  logic                last_nonce;

  assign accept     = (state == IDLE) && bus.job_valid;
  assign found      = res_digest < target;
  assign last_nonce = (remaining == 32'd1);

  assign bus.job_ready             = (state == IDLE);
  assign bus.busy                  = (state != IDLE);
  assign bus.dg_start_eval         = (state == START) && !bus.abort;
  assign bus.res_valid             = (state == DONE) && !bus.abort;
  assign bus.dg_input_val          = {nonce, header};
  assign bus.dg_input_length_bytes = 7'(MSG_BYTES);
  assign bus.res_found             = res_found;
  assign bus.res_timeout           = res_timeout;
  assign bus.res_nonce             = res_nonce;
  assign bus.res_digest            = res_digest;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (bus.job_nonce_count == 32'd0) ? DONE : START;
      START:   state_nxt = SETTLE;
      SETTLE:  state_nxt = WAIT;
      WAIT: begin
        if (bus.dg_eval_output_ready) state_nxt = CHECK;
        else if (wait_cnt == CNT_LAST) state_nxt = DONE;
      end
      CHECK:   state_nxt = (found || last_nonce) ? DONE : START;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Cancellation beats every other transition, including a ready digest.
    if (bus.abort && state != IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      header      <= '0;
      nonce       <= '0;
      remaining   <= '0;
      target      <= '0;
      wait_cnt    <= '0;
      res_found   <= 1'b0;
      res_timeout <= 1'b0;
      res_nonce   <= '0;
      res_digest  <= '0;
    end else if (accept) begin
      header      <= bus.job_header;
      target      <= bus.job_target;
      nonce       <= bus.job_nonce_start;
      remaining   <= bus.job_nonce_count;
      res_found   <= 1'b0;
      res_timeout <= 1'b0;
      res_nonce   <= bus.job_nonce_start;
      res_digest  <= '0;
    end else if (!bus.abort) begin
      case (state)
        SETTLE: wait_cnt <= '0;
        WAIT: begin
          if (bus.dg_eval_output_ready) begin
            res_digest <= bus.dg_output_val;
          end else if (wait_cnt == CNT_LAST) begin
            res_timeout <= 1'b1;
            res_found   <= 1'b0;
            res_nonce   <= nonce;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        CHECK: begin
          res_found <= found;
          res_nonce <= nonce;
          if (!found && !last_nonce) begin
            nonce     <= nonce + 64'd1;
            remaining <= remaining - 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/eaglesong_nonce_search.md
EAGLESONG_NONCE_SEARCH -- requirements
Module: eaglesong_nonce_search

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, max cycles waited for a digest before abandoning the job.
REQ-002 clk  in  1  single clock for the block; all logic is on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 job_valid  in  1  job offer; job_ready  out  1  job accept, high only in IDLE.
REQ-005 job_header  in  192  message bytes 0..23; job_nonce_start  in  64  first nonce; job_nonce_count  in  32  nonces to try; job_target  in  256  success threshold.
REQ-006 abort  in  1  synchronous cancel of the running job.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 res_valid  out  1  one-cycle result strobe; res_found  out  1; res_timeout  out  1; res_nonce  out  64; res_digest  out  256.
REQ-009 dg_input_val  out  256; dg_input_length_bytes  out  7; dg_start_eval  out  1 -- drive the digest core.
REQ-010 dg_output_val  in  256; dg_eval_output_ready  in  1 -- returned by the digest core (ready stays high until next start).

Function
REQ-011 FSM states SHALL be IDLE, START, SETTLE, WAIT, CHECK, DONE.
REQ-012 IDLE: on job_valid&&job_ready, latch header, target, nonce := job_nonce_start, remaining := job_nonce_count; go START, or DONE with res_found=0 if job_nonce_count==0 (no start pulse issued).
REQ-013 dg_input_val SHALL be registered {nonce[63:0], header[191:0]} (header byte 0 at bits 7:0, nonce LSB at bit 192); dg_input_length_bytes SHALL be constant 7'd32.
REQ-014 START: dg_start_eval=1 for exactly one cycle with dg_input_val already stable; go SETTLE.
REQ-015 SETTLE: one cycle, dg_eval_output_ready ignored (stale ready from prior run); go WAIT, clear wait counter.
REQ-016 WAIT: on dg_eval_output_ready=1 capture dg_output_val into res_digest, go CHECK; else increment counter; at counter==TIMEOUT_CYCLES-1 go DONE with res_timeout=1, res_found=0.
REQ-017 CHECK: found := (digest < target), 256-bit unsigned compare, bit 255 most significant; res_nonce := nonce.
REQ-018 CHECK: if found or remaining==1 go DONE; else nonce := nonce+1 modulo 2^64 (wraps FFFF_FFFF_FFFF_FFFF -> 0), remaining := remaining-1, go START.
REQ-019 DONE: res_valid=1 for exactly one cycle, res_* held stable until next job accepted; go IDLE.
REQ-020 abort in any non-IDLE state SHALL force IDLE next cycle, dg_start_eval=0, no res_valid; abort in IDLE ignored.
REQ-021 abort and dg_eval_output_ready in same cycle: abort wins.
REQ-022 Throughput: one start pulse per nonce; per-nonce overhead outside the core SHALL be 3 cycles (START, SETTLE, CHECK).

Reset
REQ-023 While rst_n low: state IDLE, dg_start_eval=0, dg_input_val=0, res_valid=0, res_found=0, res_timeout=0, res_nonce=0, res_digest=0, busy=0, counters 0.
REQ-024 job_ready SHALL read 1 in the first cycle after rst_n deasserts.
REQ-025 Reset mid-job SHALL discard the job with no result strobe.

Structure
REQ-026 Shared package eaglesong_pkg SHALL hold the state enum, HEADER_BYTES=24, NONCE_BYTES=8, MSG_BYTES=32, DIGEST_W=256.
REQ-027 No sub-module; the digest core is instantiated beside this block at top level, not inside it.

Verification (bench uses eaglesong_digest_top, or a fixed-latency model of it where noted)
REQ-028 target=all-ones, nonce_start=5, count=4 -> one start pulse, dg_input_val[255:192]=5, res_found=1, res_nonce=5.
REQ-029 target=0, nonce_start=5, count=3 -> start pulses carrying nonces 5,6,7, res_found=0, res_nonce=7, single res_valid.
REQ-030 target=0, nonce_start=64'hFFFF_FFFF_FFFF_FFFE, count=3 -> nonces ...FE, ...FF, 0; res_nonce=0.
REQ-031 model never raises ready, TIMEOUT_CYCLES=16 -> res_timeout=1 after 16 WAIT cycles, no further start pulse.
REQ-032 count=0 -> res_valid within 2 cycles, res_found=0, dg_start_eval never high.
REQ-033 rst_n low (then abort on a second run) during WAIT -> outputs at reset values, no res_valid, job_ready=1 afterwards, next job completes normally.
